// File: rtl/shared_qsn_demux_top.sv
// Output-side demultiplexer for the shared QSN. Delays each routing tag by the
// QSN pipeline depth and steers the shifted bit-planes to the tagged destination.
module shared_qsn_demux_top #(
  parameter int CHECK_PARALLELISM = 255,
  parameter int QSN_LATENCY       = 2
) (
  input  logic                         sys_clk,
  input  logic                         rstn,
  input  logic                         tag_valid_in,
  input  logic [2:0]                   tag_dst_in,
  input  logic                         err_clr,
  input  logic [CHECK_PARALLELISM-1:0] sw_in_bit0,
  input  logic [CHECK_PARALLELISM-1:0] sw_in_bit1,
  input  logic [CHECK_PARALLELISM-1:0] sw_in_bit2,
  input  logic [CHECK_PARALLELISM-1:0] sw_in_bit3,
  output logic [CHECK_PARALLELISM-1:0] dst0_bit0,
  output logic [CHECK_PARALLELISM-1:0] dst0_bit1,
  output logic [CHECK_PARALLELISM-1:0] dst0_bit2,
  output logic [CHECK_PARALLELISM-1:0] dst0_bit3,
  output logic [CHECK_PARALLELISM-1:0] dst1_bit0,
  output logic [CHECK_PARALLELISM-1:0] dst1_bit1,
  output logic [CHECK_PARALLELISM-1:0] dst1_bit2,
  output logic [CHECK_PARALLELISM-1:0] dst1_bit3,
  output logic [CHECK_PARALLELISM-1:0] dst2_bit0,
  output logic                         dst0_valid,
  output logic                         dst1_valid,
  output logic                         dst2_valid,
  output logic                         tag_err
);

  typedef struct packed {
    logic       vld;
    logic [2:0] dst;
  } tag_t;

  tag_t tag_pipe [QSN_LATENCY];
  tag_t aligned;
  logic tag_bad;
  logic cap0, cap1, cap2;

  // NOTE: all sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value; blocking would collapse the line.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < QSN_LATENCY; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0] <= tag_t'{vld: tag_valid_in, dst: tag_dst_in};
      for (int k = 1; k < QSN_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  assign aligned = tag_pipe[QSN_LATENCY-1];
  assign cap0    = aligned.vld & aligned.dst[0];
  assign cap1    = aligned.vld & aligned.dst[1];
  assign cap2    = aligned.vld & aligned.dst[2];
  assign tag_bad = aligned.vld && !(aligned.dst == 3'b001 ||
                                    aligned.dst == 3'b010 ||
                                    aligned.dst == 3'b100);

  // NOTE: the wide holding registers are reset on purpose: downstream sees
  // them before the first capture, so they must come up as zero, not X.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      dst0_bit0 <= '0;
      dst0_bit1 <= '0;
      dst0_bit2 <= '0;
      dst0_bit3 <= '0;
      dst1_bit0 <= '0;
      dst1_bit1 <= '0;
      dst1_bit2 <= '0;
      dst1_bit3 <= '0;
      dst2_bit0 <= '0;
    end else begin
      if (cap0) begin
        dst0_bit0 <= sw_in_bit0;
        dst0_bit1 <= sw_in_bit1;
        dst0_bit2 <= sw_in_bit2;
        dst0_bit3 <= sw_in_bit3;
      end
      if (cap1) begin
        dst1_bit0 <= sw_in_bit0;
        dst1_bit1 <= sw_in_bit1;
        dst1_bit2 <= sw_in_bit2;
        dst1_bit3 <= sw_in_bit3;
      end
      // Destination 2 only consumes bit-plane 0; planes 1-3 are dropped.
      if (cap2) dst2_bit0 <= sw_in_bit0;
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      dst0_valid <= 1'b0;
      dst1_valid <= 1'b0;
      dst2_valid <= 1'b0;
      tag_err    <= 1'b0;
    end else begin
      dst0_valid <= cap0;
      dst1_valid <= cap1;
      dst2_valid <= cap2;
      // A new malformed tag outranks a simultaneous clear.
      if (tag_bad)      tag_err <= 1'b1;
      else if (err_clr) tag_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shared_qsn_demux_top.sv
// Directed bench for shared_qsn_demux_top: a QSN_LATENCY=2 instance under full
// test, plus QSN_LATENCY=1 and 8 instances for the latency sweep.
module tb_shared_qsn_demux_top;
  localparam int W = 255;

  logic         sys_clk;
  logic         rstn;
  logic         tag_valid_in;
  logic [2:0]   tag_dst_in;
  logic         err_clr;
  logic [W-1:0] sw [4];

  logic [W-1:0] d0b [4];
  logic [W-1:0] d1b [4];
  logic [W-1:0] d2b0;
  logic         d0v, d1v, d2v, err;

  logic [W-1:0] s_d0b [2][4];
  logic [W-1:0] s_d1b [2][4];
  logic [W-1:0] s_d2b0 [2];
  logic         s_d0v [2];
  logic         s_d1v [2];
  logic         s_d2v [2];
  logic         s_err [2];

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] pat [4][4];
  logic [W-1:0] mpat [4];
  logic [W-1:0] qpat [4];
  logic [W-1:0] rpat [4];
  logic [W-1:0] spat [4];
  logic [2:0]   b2b_tag [4];

  shared_qsn_demux_top #(.CHECK_PARALLELISM(W), .QSN_LATENCY(2)) dut (
    .sys_clk(sys_clk), .rstn(rstn), .tag_valid_in(tag_valid_in),
    .tag_dst_in(tag_dst_in), .err_clr(err_clr),
    .sw_in_bit0(sw[0]), .sw_in_bit1(sw[1]), .sw_in_bit2(sw[2]), .sw_in_bit3(sw[3]),
    .dst0_bit0(d0b[0]), .dst0_bit1(d0b[1]), .dst0_bit2(d0b[2]), .dst0_bit3(d0b[3]),
    .dst1_bit0(d1b[0]), .dst1_bit1(d1b[1]), .dst1_bit2(d1b[2]), .dst1_bit3(d1b[3]),
    .dst2_bit0(d2b0), .dst0_valid(d0v), .dst1_valid(d1v), .dst2_valid(d2v),
    .tag_err(err)
  );

  for (genvar g = 0; g < 2; g++) begin : g_sweep
    shared_qsn_demux_top #(.CHECK_PARALLELISM(W), .QSN_LATENCY(g == 0 ? 1 : 8)) dut_s (
      .sys_clk(sys_clk), .rstn(rstn), .tag_valid_in(tag_valid_in),
      .tag_dst_in(tag_dst_in), .err_clr(err_clr),
      .sw_in_bit0(sw[0]), .sw_in_bit1(sw[1]), .sw_in_bit2(sw[2]), .sw_in_bit3(sw[3]),
      .dst0_bit0(s_d0b[g][0]), .dst0_bit1(s_d0b[g][1]),
      .dst0_bit2(s_d0b[g][2]), .dst0_bit3(s_d0b[g][3]),
      .dst1_bit0(s_d1b[g][0]), .dst1_bit1(s_d1b[g][1]),
      .dst1_bit2(s_d1b[g][2]), .dst1_bit3(s_d1b[g][3]),
      .dst2_bit0(s_d2b0[g]), .dst0_valid(s_d0v[g]), .dst1_valid(s_d1v[g]),
      .dst2_valid(s_d2v[g]), .tag_err(s_err[g])
    );
  end

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [W-1:0] observed,
                       input logic [W-1:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = (v << 32) | W'($urandom);
    return v;
  endfunction

  task automatic set_sw(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] d);
    sw[0] = a; sw[1] = b; sw[2] = c; sw[3] = d;
  endtask

  task automatic check_valids(input string tag, input logic e0, input logic e1,
                              input logic e2);
    check({tag, " dst0_valid"}, W'(d0v), W'(e0));
    check({tag, " dst1_valid"}, W'(d1v), W'(e1));
    check({tag, " dst2_valid"}, W'(d2v), W'(e2));
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s dst0_bit%0d", tag, k), d0b[k], '0);
      check($sformatf("%s dst1_bit%0d", tag, k), d1b[k], '0);
    end
    check({tag, " dst2_bit0"}, d2b0, '0);
    check_valids(tag, 1'b0, 1'b0, 1'b0);
    check({tag, " tag_err"}, W'(err), '0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) pat[i][k] = rnd();
      mpat[i] = rnd();
      qpat[i] = rnd();
      rpat[i] = rnd();
      spat[i] = rnd();
    end
    b2b_tag[0] = 3'b001; b2b_tag[1] = 3'b100; b2b_tag[2] = 3'b001; b2b_tag[3] = 3'b010;

    // Reset held with live, garbage inputs.
    rstn = 1'b0; tag_valid_in = 1'b1; tag_dst_in = 3'b111; err_clr = 1'b0;
    set_sw(rnd(), rnd(), rnd(), rnd());
    tick(); tick();
    check_all_zero("reset");
    for (int g = 0; g < 2; g++) check($sformatf("reset sweep%0d valid", g), W'(s_d1v[g]), '0);
    rstn = 1'b1; tag_valid_in = 1'b0; tag_dst_in = 3'b000;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_valids($sformatf("post-reset c%0d", c), 1'b0, 1'b0, 1'b0);
      check($sformatf("post-reset c%0d dst0_bit0", c), d0b[0], '0);
    end

    // Single beat to dst1, data at cycle 2, outputs in cycle 3.
    set_sw('0, '0, '0, '0);
    tag_valid_in = 1'b1; tag_dst_in = 3'b010;
    tick();                                   // cycle 1
    tag_valid_in = 1'b0; tag_dst_in = 3'b000;
    check_valids("single c1", 1'b0, 1'b0, 1'b0);
    tick();                                   // cycle 2
    check_valids("single c2", 1'b0, 1'b0, 1'b0);
    set_sw(W'(1), W'(2), W'(4), W'(8));
    tick();                                   // cycle 3
    check_valids("single c3", 1'b0, 1'b1, 1'b0);
    check("single dst1_bit0", d1b[0], W'(1));
    check("single dst1_bit1", d1b[1], W'(2));
    check("single dst1_bit2", d1b[2], W'(4));
    check("single dst1_bit3", d1b[3], W'(8));
    check("single dst0_bit0", d0b[0], '0);
    check("single dst2_bit0", d2b0, '0);
    set_sw('0, '0, '0, '0);
    tick();                                   // cycle 4
    check_valids("single c4", 1'b0, 1'b0, 1'b0);
    check("single hold dst1_bit0", d1b[0], W'(1));

    // Back-to-back mix dst0, dst2, dst0, dst1.
    for (int c = 0; c < 8; c++) begin
      check_valids($sformatf("b2b c%0d", c), (c == 3) || (c == 5), c == 6, c == 4);
      if (c == 3) for (int k = 0; k < 4; k++)
        check($sformatf("b2b c3 dst0_bit%0d", k), d0b[k], pat[0][k]);
      if (c == 4) begin
        check("b2b c4 dst2_bit0", d2b0, pat[1][0]);
        check("b2b c4 dst0 hold", d0b[0], pat[0][0]);
      end
      if (c == 5) for (int k = 0; k < 4; k++)
        check($sformatf("b2b c5 dst0_bit%0d", k), d0b[k], pat[2][k]);
      if (c == 6) for (int k = 0; k < 4; k++)
        check($sformatf("b2b c6 dst1_bit%0d", k), d1b[k], pat[3][k]);
      tag_valid_in = (c < 4);
      tag_dst_in = (c < 4) ? b2b_tag[c] : 3'b000;
      if (c >= 2 && c <= 5) set_sw(pat[c-2][0], pat[c-2][1], pat[c-2][2], pat[c-2][3]);
      else set_sw('0, '0, '0, '0);
      tick();
    end

    // Malformed tags and tag_err set/clear priority.
    for (int c = 0; c < 11; c++) begin
      if (c == 2) check("bad c2 tag_err", W'(err), '0);
      if (c == 3) begin
        check_valids("bad c3", 1'b1, 1'b1, 1'b0);
        check("bad c3 dst0_bit0", d0b[0], mpat[0]);
        check("bad c3 dst1_bit0", d1b[0], mpat[0]);
        check("bad c3 dst1_bit3", d1b[3], mpat[3]);
        check("bad c3 tag_err", W'(err), W'(1));
      end
      if (c == 6) begin
        check_valids("bad c6", 1'b0, 1'b0, 1'b0);
        check("bad c6 dst0 hold", d0b[0], mpat[0]);
        check("bad c6 tag_err", W'(err), W'(1));
      end
      if (c == 7) check("bad c7 cleared", W'(err), '0);
      if (c == 10) begin
        check_valids("bad c10", 1'b1, 1'b0, 1'b1);
        check("bad c10 dst2_bit0", d2b0, rpat[0]);
        check("bad c10 set beats clr", W'(err), W'(1));
      end
      tag_valid_in = (c == 0) || (c == 3) || (c == 7);
      tag_dst_in = (c == 0) ? 3'b011 : (c == 7) ? 3'b101 : 3'b000;
      err_clr = (c == 6) || (c == 9);
      if (c == 2) set_sw(mpat[0], mpat[1], mpat[2], mpat[3]);
      else if (c == 5) set_sw(qpat[0], qpat[1], qpat[2], qpat[3]);
      else if (c == 9) set_sw(rpat[0], rpat[1], rpat[2], rpat[3]);
      else set_sw('0, '0, '0, '0);
      tick();
    end
    err_clr = 1'b0;

    // Reset mid-flight: two tags issued, reset before they align.
    set_sw(rnd(), rnd(), rnd(), rnd());
    tag_valid_in = 1'b1; tag_dst_in = 3'b001;
    tick();
    tag_dst_in = 3'b010;
    tick();
    rstn = 1'b0; tag_valid_in = 1'b0; tag_dst_in = 3'b000;
    tick();
    rstn = 1'b1;
    check_all_zero("midflight release");
    for (int c = 0; c < 5; c++) begin
      tick();
      check_valids($sformatf("midflight c%0d", c), 1'b0, 1'b0, 1'b0);
    end
    check_all_zero("midflight after");

    // Latency sweep: one dst1 beat, data held steady across all alignments.
    set_sw(spat[0], spat[1], spat[2], spat[3]);
    tag_valid_in = 1'b1; tag_dst_in = 3'b010;
    for (int c = 1; c <= 10; c++) begin
      tick();
      tag_valid_in = 1'b0; tag_dst_in = 3'b000;
      check($sformatf("sweep L1 c%0d", c), W'(s_d1v[0]), W'(c == 2));
      check($sformatf("sweep L2 c%0d", c), W'(d1v), W'(c == 3));
      check($sformatf("sweep L8 c%0d", c), W'(s_d1v[1]), W'(c == 9));
      if (c == 9) check("sweep L8 dst1_bit2", s_d1b[1][2], spat[2]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shared_qsn_demux_top.md
# shared_qsn_demux_top

Output-side demultiplexer for the shared quasi-cyclic shift network (QSN) in the layered decoder's permutation network. The input side time-shares one QSN between up to three message sources (bit-plane 0 from three sources, bit-planes 1-3 from two). This block tracks each routing tag through the QSN pipeline and steers the shifted bit-planes to the matching destination holding registers. Each capture raises a one-cycle valid pulse toward that destination.

## Interface
Parameters:
- CHECK_PARALLELISM, 255: width of each bit-plane (one bit per check-node lane).
- QSN_LATENCY, 2: cycles from tag issue to shifted data at `sw_in_bit*`. Legal range 1..8. It must equal the QSN plus zero-shuffle pipeline depth.

Ports:
- sys_clk  in  1  single clock; all state is on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- tag_valid_in  in  1  high in the cycle a beat is loaded into the shared QSN input mux.
- tag_dst_in  in  3  destination select, one-hot: [0]=dst0, [1]=dst1, [2]=dst2. Sampled only when tag_valid_in=1.
- err_clr  in  1  synchronous clear of tag_err.
- sw_in_bit0..sw_in_bit3  in  CHECK_PARALLELISM each  shifted bit-planes from the shared QSN.
- dst0_bit0..dst0_bit3  out  CHECK_PARALLELISM each  destination-0 holding registers.
- dst1_bit0..dst1_bit3  out  CHECK_PARALLELISM each  destination-1 holding registers.
- dst2_bit0  out  CHECK_PARALLELISM  destination-2 holding register (bit-plane 0 only).
- dst0_valid, dst1_valid, dst2_valid  out  1 each  one-cycle capture pulse per destination.
- tag_err  out  1  sticky flag for a malformed tag.

## Operation
- **Tag delay line**
  - QSN_LATENCY stages, each 1 valid bit plus 3 tag bits.
  - Stage 0 loads {tag_valid_in, tag_dst_in} every cycle, without gating.
  - Stage k loads stage k-1.
  - The last stage (the aligned tag) lines up with the data present on `sw_in_bit*`.
- **Capture** happens when the aligned valid bit is 1:
  - aligned tag[0]=1: dst0_bit0..3 <= sw_in_bit0..3.
  - aligned tag[1]=1: dst1_bit0..3 <= sw_in_bit0..3.
  - aligned tag[2]=1: dst2_bit0 <= sw_in_bit0. Bit-planes 1-3 are discarded.
  - Multiple tag bits set: every selected destination captures (broadcast). tag_err is also set.
  - tag 3'b000 with valid=1: no destination captures, and tag_err is set.
- **Hold**: destination registers keep their last captured value until their next capture. They are never cleared except by reset.
- **Valid pulses**: dstN_valid <= aligned valid & aligned tag[N], registered. A pulse is asserted in the same cycle the new data is first visible.
- **tag_err**
  - Set when aligned valid=1 and the aligned tag is not one-hot.
  - err_clr=1 clears it.
  - If a set and a clear happen in the same cycle, set wins and tag_err stays 1.
- Tags with tag_valid_in=0 are ignored and cannot raise tag_err.

## Timing
- Reset values (asynchronous on rstn low):
  - All delay-line stages are 0.
  - All dst*_bit* are 0.
  - All dst*_valid are 0.
  - tag_err is 0.
- Latency:
  - A tag issued in cycle t is aligned with `sw_in_bit*` in cycle t+QSN_LATENCY.
  - Outputs and valid are visible in cycle t+QSN_LATENCY+1, i.e. QSN_LATENCY+1 cycles after issue.
- Throughput: one beat per cycle, with no bubbles required.
  - Back-to-back beats to the same destination give a continuous valid high, with the data updating every cycle.
  - Alternating destinations give alternating pulses.
- No backpressure: destinations must accept each pulse. Data is not retained elsewhere.
- Reset mid-flight: in-flight tags are discarded. No valid pulse may occur in the first QSN_LATENCY+1 cycles after rstn deasserts unless new tags are issued.

## Test plan
- **Reset**: hold rstn=0 with random sw_in and tag_valid_in=1. Required: all outputs 0 and tag_err=0. After release with tag_valid_in=0, all outputs stay 0.
- **Single beat, QSN_LATENCY=2**: tag_valid_in=1, tag_dst_in=3'b010 at cycle 0; sw_in_bit0..3 = 0x1, 0x2, 0x4, 0x8 (zero-extended) at cycle 2. Required:
  - dst1_bit0..3 = 0x1, 0x2, 0x4, 0x8 and dst1_valid=1 in cycle 3 only.
  - dst0 and dst2 remain 0.
- **Back-to-back mix**: tags dst0, dst2, dst0, dst1 on consecutive cycles, each carrying a distinct sw_in pattern. Required:
  - Pulses in cycles 3, 4, 5, 6 on dst0, dst2, dst0, dst1 respectively.
  - dst2_bit0 is updated and dst0 holds its cycle-3 value during cycle 4.
- **Malformed tags**:
  - tag 3'b011 with valid: dst0 and dst1 both capture the same data, and tag_err rises in cycle 3.
  - A later tag 3'b000: no capture, and tag_err stays 1.
  - err_clr pulsed alone: tag_err goes to 0.
  - err_clr coincident with a bad aligned tag: tag_err stays 1.
- **Reset mid-flight**: issue 2 valid tags, then assert rstn for 1 cycle before alignment. Required: no valid pulses, and all registers are 0 after release.
- **Latency sweep**: repeat the single-beat test for QSN_LATENCY=1 and QSN_LATENCY=8. Required: the pulse appears exactly QSN_LATENCY+1 cycles after issue.
